// File: rtl/isp_awb_gain_if.sv
// Pixel bus between ISP stages: line/frame syncs plus one RGB pixel per clock.
interface isp_awb_gain_if #(
    parameter int BITS = 8
);
    logic            href;
    logic            vsync;
    logic [BITS-1:0] r;
    logic [BITS-1:0] g;
    logic [BITS-1:0] b;

    modport master (output href, vsync, r, g, b);
    modport slave  (input  href, vsync, r, g, b);
endinterface

// File: rtl/isp_awb_gain.sv
// Auto white balance: applies R/B gains to the pixel stream (2-cycle path) and
// derives new gains from gray-world statistics gathered over each frame.
module isp_awb_gain #(
    parameter int BITS     = 8,
    parameter int GAIN_W   = 12,
    parameter int FRAC     = 8,
    parameter int ACC_W    = 32,
    parameter int SAT_THR  = 250,
    parameter int DARK_THR = 5,
    parameter int MIN_CNT  = 1024
) (
    input  logic               pclk,
    input  logic               rst_n,
    input  logic               awb_en,
    isp_awb_gain_if.slave      pix_in,
    isp_awb_gain_if.master     pix_out,
    output logic [GAIN_W-1:0]  gain_r,
    output logic [GAIN_W-1:0]  gain_b,
    output logic               gains_valid
);
    localparam int PW = BITS + GAIN_W;            // product width
    localparam int DW = ACC_W + GAIN_W + FRAC;    // divider datapath width
    localparam int CW = $clog2(GAIN_W);
    localparam logic [GAIN_W-1:0] UNITY    = GAIN_W'(1 << FRAC);
    localparam logic [GAIN_W-1:0] GAIN_MAX = '1;
    localparam logic [BITS-1:0]   PIX_MAX  = '1;
    localparam logic [ACC_W-1:0]  ACC_MAX  = '1;

    typedef enum logic [2:0] {IDLE, CHECK, DIV_R, DIV_B, COMMIT} state_t;

    function automatic logic [BITS-1:0] sat_pix(input logic [PW-1:0] p);
        logic [PW-1:0] s;
        s = p >> FRAC;
        return (s > PW'(PIX_MAX)) ? PIX_MAX : s[BITS-1:0];
    endfunction

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ACC_W] ? ACC_MAX : s[ACC_W-1:0];
    endfunction

    // ---------------- pixel path ----------------
    logic [PW-1:0]   prod_r_q, prod_r_d, prod_b_q, prod_b_d;
    logic [BITS-1:0] g1_q, out_r_q, out_r_d, out_g_q, out_g_d, out_b_q, out_b_d;
    logic            href1_q, vsync1_q, href2_q, vsync2_q;
    logic [GAIN_W-1:0] gain_r_q, gain_r_d, gain_b_q, gain_b_d;
    logic [GAIN_W-1:0] gain_r_eff, gain_b_eff;

    // Stage 1 multiplies by the active (or unity) gain; stage 2 scales, clamps, blanks.
    always_comb begin
        gain_r_eff = awb_en ? gain_r_q : UNITY;
        gain_b_eff = awb_en ? gain_b_q : UNITY;
        prod_r_d   = PW'(pix_in.r) * PW'(gain_r_eff);
        prod_b_d   = PW'(pix_in.b) * PW'(gain_b_eff);
        out_r_d    = href1_q ? sat_pix(prod_r_q) : '0;
        out_g_d    = href1_q ? g1_q : '0;
        out_b_d    = href1_q ? sat_pix(prod_b_q) : '0;
    end

    // Pixel pipeline registers.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            prod_r_q <= '0; prod_b_q <= '0; g1_q <= '0;
            href1_q  <= 1'b0; vsync1_q <= 1'b0;
            out_r_q  <= '0; out_g_q <= '0; out_b_q <= '0;
            href2_q  <= 1'b0; vsync2_q <= 1'b0;
        end else begin
            prod_r_q <= prod_r_d; prod_b_q <= prod_b_d; g1_q <= pix_in.g;
            href1_q  <= pix_in.href; vsync1_q <= pix_in.vsync;
            out_r_q  <= out_r_d; out_g_q <= out_g_d; out_b_q <= out_b_d;
            href2_q  <= href1_q; vsync2_q <= vsync1_q;
        end
    end

    assign pix_out.href  = href2_q;
    assign pix_out.vsync = vsync2_q;
    assign pix_out.r     = out_r_q;
    assign pix_out.g     = out_g_q;
    assign pix_out.b     = out_b_q;

    // ---------------- statistics ----------------
    logic [ACC_W-1:0] sum_r_q, sum_r_d, sum_g_q, sum_g_d, sum_b_q, sum_b_d, cnt_q, cnt_d;
    logic             in_range, incl_pix, frame_end;

    // Gray-world accumulation; vsync1_q doubles as the registered vsync for edge detect.
    always_comb begin
        in_range  = (int'(pix_in.r) >= DARK_THR) && (int'(pix_in.r) < SAT_THR) &&
                    (int'(pix_in.g) >= DARK_THR) && (int'(pix_in.g) < SAT_THR) &&
                    (int'(pix_in.b) >= DARK_THR) && (int'(pix_in.b) < SAT_THR);
        incl_pix  = pix_in.href && !pix_in.vsync && in_range;
        frame_end = pix_in.vsync && !vsync1_q;
        sum_r_d   = sum_r_q;
        sum_g_d   = sum_g_q;
        sum_b_d   = sum_b_q;
        cnt_d     = cnt_q;
        if (frame_end) begin
            sum_r_d = '0; sum_g_d = '0; sum_b_d = '0; cnt_d = '0;
        end else if (incl_pix) begin
            sum_r_d = sat_add(sum_r_q, ACC_W'(pix_in.r));
            sum_g_d = sat_add(sum_g_q, ACC_W'(pix_in.g));
            sum_b_d = sat_add(sum_b_q, ACC_W'(pix_in.b));
            cnt_d   = sat_add(cnt_q, ACC_W'(1));
        end
    end

    // ---------------- gain computation FSM ----------------
    state_t            state_q, state_d;
    logic [ACC_W-1:0]  div_r_q, div_r_d, div_g_q, div_g_d, div_b_q, div_b_d, div_cnt_q, div_cnt_d;
    logic [DW-1:0]     rem_q, rem_d, dvs_q, dvs_d, dividend;
    logic [GAIN_W-1:0] quo_q, quo_d, quo_next, new_r_q, new_r_d, new_b_q, new_b_d;
    logic [CW-1:0]     bit_q, bit_d;
    logic              ovf_r_q, ovf_r_d, ovf_b_q, ovf_b_d, ge, gv_d;

    // Next-state logic: snapshot, qualify, two restoring divisions, commit.
    always_comb begin
        state_d   = state_q;
        div_r_d   = div_r_q; div_g_d = div_g_q; div_b_d = div_b_q; div_cnt_d = div_cnt_q;
        rem_d     = rem_q; dvs_d = dvs_q; quo_d = quo_q; bit_d = bit_q;
        ovf_r_d   = ovf_r_q; ovf_b_d = ovf_b_q;
        new_r_d   = new_r_q; new_b_d = new_b_q;
        gain_r_d  = gain_r_q; gain_b_d = gain_b_q;
        gv_d      = 1'b0;
        dividend  = DW'(div_g_q) << FRAC;
        ge        = rem_q >= dvs_q;
        quo_next  = {quo_q[GAIN_W-2:0], ge};

        // A frame end while busy only clears the accumulators; the snapshot
        // must stay intact until the running computation is done.
        if (frame_end && state_q == IDLE) begin
            div_r_d = sum_r_q; div_g_d = sum_g_q; div_b_d = sum_b_q; div_cnt_d = cnt_q;
            state_d = CHECK;
        end

        case (state_q)
            CHECK: begin
                if (div_cnt_q < ACC_W'(MIN_CNT) || div_r_q == '0 || div_b_q == '0 || !awb_en) begin
                    state_d = IDLE;
                end else begin
                    state_d = DIV_R;
                    // Quotient overflows GAIN_W bits iff dividend >= divisor << GAIN_W.
                    ovf_r_d = dividend >= (DW'(div_r_q) << GAIN_W);
                    ovf_b_d = dividend >= (DW'(div_b_q) << GAIN_W);
                    rem_d   = dividend;
                    dvs_d   = DW'(div_r_q) << (GAIN_W - 1);
                    quo_d   = '0;
                    bit_d   = CW'(GAIN_W - 1);
                end
            end
            DIV_R, DIV_B: begin
                rem_d = ge ? rem_q - dvs_q : rem_q;
                dvs_d = dvs_q >> 1;
                quo_d = quo_next;
                bit_d = bit_q - CW'(1);
                if (bit_q == '0) begin
                    if (state_q == DIV_R) begin
                        new_r_d = ovf_r_q ? GAIN_MAX : quo_next;
                        rem_d   = dividend;
                        dvs_d   = DW'(div_b_q) << (GAIN_W - 1);
                        quo_d   = '0;
                        bit_d   = CW'(GAIN_W - 1);
                        state_d = DIV_B;
                    end else begin
                        new_b_d = ovf_b_q ? GAIN_MAX : quo_next;
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                gain_r_d = new_r_q;
                gain_b_d = new_b_q;
                gv_d     = 1'b1;
                state_d  = IDLE;
            end
            default: ;
        endcase
    end

    // Statistics, divider and gain registers; reset drops any partial result.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r_q <= '0; sum_g_q <= '0; sum_b_q <= '0; cnt_q <= '0;
            state_q <= IDLE;
            div_r_q <= '0; div_g_q <= '0; div_b_q <= '0; div_cnt_q <= '0;
            rem_q <= '0; dvs_q <= '0; quo_q <= '0; bit_q <= '0;
            ovf_r_q <= 1'b0; ovf_b_q <= 1'b0;
            new_r_q <= UNITY; new_b_q <= UNITY;
            gain_r_q <= UNITY; gain_b_q <= UNITY;
            gains_valid <= 1'b0;
        end else begin
            sum_r_q <= sum_r_d; sum_g_q <= sum_g_d; sum_b_q <= sum_b_d; cnt_q <= cnt_d;
            state_q <= state_d;
            div_r_q <= div_r_d; div_g_q <= div_g_d; div_b_q <= div_b_d; div_cnt_q <= div_cnt_d;
            rem_q <= rem_d; dvs_q <= dvs_d; quo_q <= quo_d; bit_q <= bit_d;
            ovf_r_q <= ovf_r_d; ovf_b_q <= ovf_b_d;
            new_r_q <= new_r_d; new_b_q <= new_b_d;
            gain_r_q <= gain_r_d; gain_b_q <= gain_b_d;
            gains_valid <= gv_d;
        end
    end

    assign gain_r = gain_r_q;
    assign gain_b = gain_b_q;
endmodule

// File: doc/isp_awb_gain.md
ISP_AWB_GAIN -- requirements
Module: isp_awb_gain

Interface
REQ-001 SHALL have parameter BITS, default 8, pixel channel width.
REQ-002 SHALL have parameter GAIN_W, default 12, unsigned gain width.
REQ-003 SHALL have parameter FRAC, default 8, gain fraction bits; 1.0 = 256.
REQ-004 SHALL have parameter ACC_W, default 32, accumulator and pixel-count width.
REQ-005 SHALL have parameter SAT_THR, default 250; a pixel is excluded if any channel >= SAT_THR.
REQ-006 SHALL have parameter DARK_THR, default 5; a pixel is excluded if any channel < DARK_THR.
REQ-007 SHALL have parameter MIN_CNT, default 1024, minimum included pixels for a gain update.
REQ-008 Ports:
  pclk  in  1  pixel clock, rising edge.
  rst_n  in  1  reset, asynchronous, active-low.
  awb_en  in  1  1 = apply computed gains; 0 = unity gain, no commit.
  in_href  in  1  line-valid from the demosaic stage.
  in_vsync  in  1  frame sync, active high.
  in_r/in_g/in_b  in  BITS  RGB pixel.
  out_href  out  1  in_href delayed by 2 cycles.
  out_vsync  out  1  in_vsync delayed by 2 cycles.
  out_r/out_g/out_b  out  BITS  gain-corrected pixel.
  gain_r/gain_b  out  GAIN_W  active gains, UQ(GAIN_W-FRAC).FRAC.
  gains_valid  out  1  one-cycle pulse on gain commit.

Function
REQ-009 Pixel path latency SHALL be exactly 2 cycles: stage 1 multiplies; stage 2 shifts right by FRAC and saturates to 2^BITS-1.
REQ-010 out_r SHALL be sat((in_r*gain_r)>>FRAC) and out_b SHALL be sat((in_b*gain_b)>>FRAC); out_g SHALL be in_g delayed; products SHALL be BITS+GAIN_W bits wide, truncated (floor).
REQ-011 When awb_en=0, the pixel path SHALL use 1<<FRAC for both gains.
REQ-012 out_r/g/b SHALL be 0 whenever out_href=0.
REQ-013 Statistics SHALL include a pixel when in_href=1, in_vsync=0, and it passes the SAT_THR and DARK_THR tests.
REQ-014 Each included pixel SHALL add to sum_r, sum_g and sum_b and increment cnt; every accumulator SHALL saturate at 2^ACC_W-1.
REQ-015 Frame end SHALL be the rising edge of in_vsync, detected against a registered copy of in_vsync.
REQ-016 On frame end, the block SHALL snapshot sum_r/g/b and cnt into divider registers and clear the accumulators in the same cycle.
REQ-017 The FSM SHALL have states IDLE, CHECK, DIV_R, DIV_B, COMMIT.
REQ-018 IDLE -> CHECK on frame end.
REQ-019 CHECK SHALL go to IDLE without committing if cnt < MIN_CNT, sum_r = 0, sum_b = 0, or awb_en = 0; otherwise CHECK -> DIV_R.
REQ-020 DIV_R SHALL compute gain_r_new = floor((sum_g<<FRAC)/sum_r) by restoring division, one quotient bit per cycle, MSB first, GAIN_W cycles; DIV_B SHALL compute gain_b_new the same way from sum_b.
REQ-021 If a quotient is >= 2^GAIN_W, that result SHALL be 2^GAIN_W-1, detected by a pre-compare before iterating.
REQ-022 COMMIT SHALL load gain_r and gain_b, pulse gains_valid for 1 cycle, then return to IDLE.
REQ-023 The total busy time is 2*GAIN_W+3 cycles; vertical blanking SHALL be at least that long.
REQ-024 A frame end that occurs while the FSM is not IDLE SHALL still clear the accumulators, SHALL be otherwise ignored, and the current computation SHALL finish.
REQ-025 Active gains SHALL change only in COMMIT, so gains stay constant within a frame.

Reset
REQ-026 On rst_n low, regardless of state: FSM -> IDLE; accumulators, cnt, delay lines and out_* = 0; gains_valid = 0; gain_r = gain_b = 1<<FRAC (256).
REQ-027 Reset asserted mid-division SHALL discard the partial result; the first frame end after release SHALL start a fresh computation.

Verification
REQ-028 Reset: hold rst_n low -> all out_* = 0, gain_r = gain_b = 256, gains_valid = 0.
REQ-029 Unity: after reset, pixel (100,150,200) with href=1 -> out (100,150,200) exactly 2 cycles later with out_href=1.
REQ-030 Update: 2048 pixels of (64,128,32), then vsync rise -> gains_valid within 27 cycles with gain_r = 512 and gain_b = 1024; in the next frame, (64,128,32) -> (128,128,128).
REQ-031 Clamp: 2048 pixels of (8,200,100), then vsync rise -> gain_r = 4095, gain_b = 512; in the next frame, (8,200,100) -> (127,200,200).
REQ-032 Exclusion: a frame with all pixels at g = 255, or only 1000 valid pixels -> no gains_valid pulse, gains unchanged; awb_en = 0 -> pixels pass unchanged and there is no commit.
REQ-033 Reset in DIV_R, then release -> gains = 256, no gains_valid pulse; the next valid frame updates normally.
